// File: rtl/sseg_scan_decoder_if.sv
// Pin-level bundle shared by the seven-segment scan driver side and the
// receive-side decoder: multiplexed anode/cathode pins plus decoded results.
interface sseg_scan_decoder_if;
  logic [7:0]  anode;        // active-low digit select
  logic [7:0]  cathodes;     // active-low segments, [6:0]=gfedcba, [7]=dp
  logic [31:0] disp_word;    // decoded nibbles, digit i at [4i+3:4i]
  logic [7:0]  dp_word;      // captured decimal points, active-high
  logic [7:0]  digit_valid;  // digit i holds a legal hex glyph
  logic        frame_done;   // all 8 digits captured since last pulse/reset
  logic        pattern_err;  // captured segment pattern not a glyph nor blank
  logic        anode_err;    // captured with more than one anode low

  // Side that drives the pins and observes the decoded results.
  modport master (
    output anode, cathodes,
    input  disp_word, dp_word, digit_valid, frame_done, pattern_err, anode_err
  );

  // Decoder side: samples the pins, produces the decoded results.
  modport slave (
    input  anode, cathodes,
    output disp_word, dp_word, digit_valid, frame_done, pattern_err, anode_err
  );
endinterface

// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder: samples multiplexed 7-segment pins, waits for each pin
// pattern to settle, and decodes settled single-digit patterns back into the
// 32-bit display word, decimal points and per-digit validity.
module sseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  sseg_scan_decoder_if.slave pins_if
);

  localparam int unsigned   CW       = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Glyph lookup: bit 4 = legal hex glyph, bits [3:0] = nibble.
  function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'h00;
    case (seg)
      7'h3F:   res = 5'h10;
      7'h06:   res = 5'h11;
      7'h5B:   res = 5'h12;
      7'h4F:   res = 5'h13;
      7'h66:   res = 5'h14;
      7'h6D:   res = 5'h15;
      7'h7D:   res = 5'h16;
      7'h07:   res = 5'h17;
      7'h7F:   res = 5'h18;
      7'h6F:   res = 5'h19;
      7'h77:   res = 5'h1A;
      7'h7C:   res = 5'h1B;
      7'h39:   res = 5'h1C;
      7'h5E:   res = 5'h1D;
      7'h79:   res = 5'h1E;
      7'h71:   res = 5'h1F;
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  // True when more than one select bit is active.
  function automatic logic multi_active(input logic [7:0] sel);
    return ((sel & (sel - 8'd1)) != 8'd0);
  endfunction

  // Position of the (single) active select bit; 0 when none is active.
  function automatic logic [2:0] onehot_index(input logic [7:0] sel);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [SYNC_STAGES-1:0][7:0] an_sync_q;
  logic [SYNC_STAGES-1:0][7:0] ca_sync_q;
  logic [15:0]                 prev_q;
  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [7:0]                  seen_q, seen_d;
  logic [31:0]                 disp_q, disp_d;
  logic [7:0]                  dp_q, dp_d;
  logic [7:0]                  valid_q, valid_d;
  logic                        frame_q, frame_d;
  logic                        perr_q, perr_d;
  logic                        aerr_q, aerr_d;

  logic [7:0]  sample_an_s;
  logic [7:0]  sample_ca_s;
  logic [15:0] sample_s;
  logic        changed_s;
  logic        capture_s;
  logic [7:0]  sel_s;
  logic [6:0]  seg_s;
  logic [4:0]  dec_s;
  logic [2:0]  idx_s;
  logic [7:0]  seen_next_s;

  assign sample_an_s = an_sync_q[SYNC_STAGES-1];
  assign sample_ca_s = ca_sync_q[SYNC_STAGES-1];
  assign sample_s    = {sample_an_s, sample_ca_s};
  assign changed_s   = (sample_s != prev_q);
  assign sel_s       = ~sample_an_s;
  assign seg_s       = ~sample_ca_s[6:0];
  assign dec_s       = glyph_decode(seg_s);
  assign idx_s       = onehot_index(sel_s);
  assign seen_next_s = seen_q | (8'd1 << idx_s);

  // Synchronizer chains; reset loads the inactive (all ones) pin level.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      an_sync_q <= '1;
      ca_sync_q <= '1;
      prev_q    <= 16'hFFFF;
    end else begin
      an_sync_q <= {an_sync_q[SYNC_STAGES-2:0], pins_if.anode};
      ca_sync_q <= {ca_sync_q[SYNC_STAGES-2:0], pins_if.cathodes};
      prev_q    <= sample_s;
    end
  end

  // Stability tracker next state: one capture per stable interval.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_s = 1'b0;
    if (changed_s) begin
      state_d = ST_WAIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q >= CNT_LAST) begin
            capture_s = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_HOLD: begin
          state_d = ST_HOLD;
        end
        default: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Capture decode: anode classification, glyph decode and frame tracking.
  always_comb begin
    disp_d  = disp_q;
    dp_d    = dp_q;
    valid_d = valid_q;
    seen_d  = seen_q;
    frame_d = 1'b0;
    perr_d  = 1'b0;
    aerr_d  = 1'b0;
    if (capture_s) begin
      if (sel_s == 8'h00) begin
        // Blanking interval between digits: nothing to record.
        seen_d = seen_q;
      end else if (multi_active(sel_s)) begin
        aerr_d = 1'b1;
      end else begin
        if (seg_s == 7'h00) begin
          valid_d[idx_s]                = 1'b0;
          disp_d[{idx_s, 2'b00} +: 4]   = 4'h0;
          dp_d[idx_s]                   = ~sample_ca_s[7];
        end else if (dec_s[4]) begin
          valid_d[idx_s]                = 1'b1;
          disp_d[{idx_s, 2'b00} +: 4]   = dec_s[3:0];
          dp_d[idx_s]                   = ~sample_ca_s[7];
        end else begin
          // Unknown pattern keeps the old nibble but is no longer trusted.
          perr_d         = 1'b1;
          valid_d[idx_s] = 1'b0;
        end
        if (seen_next_s == 8'hFF) begin
          frame_d = 1'b1;
          seen_d  = 8'h00;
        end else begin
          seen_d = seen_next_s;
        end
      end
    end else begin
      seen_d = seen_q;
    end
  end

  // State, counter, frame mask and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      seen_q  <= 8'h00;
      disp_q  <= 32'h0000_0000;
      dp_q    <= 8'h00;
      valid_q <= 8'h00;
      frame_q <= 1'b0;
      perr_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      disp_q  <= disp_d;
      dp_q    <= dp_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      perr_q  <= perr_d;
      aerr_q  <= aerr_d;
    end
  end

  assign pins_if.disp_word   = disp_q;
  assign pins_if.dp_word     = dp_q;
  assign pins_if.digit_valid = valid_q;
  assign pins_if.frame_done  = frame_q;
  assign pins_if.pattern_err = perr_q;
  assign pins_if.anode_err   = aerr_q;

endmodule

// File: doc/sseg_scan_decoder.md
# sseg_scan_decoder

Receive-side counterpart of the 8-digit seven-segment scan driver. It samples the multiplexed `anode`/`cathodes` pins, filters out transitions and ghosting, and decodes each settled cathode pattern back to a hex nibble. It rebuilds the 32-bit display word that the driver was given. The block is used for loopback self-test of the banner path and as a bench monitor; it sits beside the driver and observes the same pins.

## Interface
- `STABLE_CYCLES`, default 16: consecutive identical synchronized samples required before a capture. Legal range is 2 to 65535.
- `SYNC_STAGES`, default 2: synchronizer depth on `anode` and `cathodes`. Minimum 2.
- `clk` in 1: single clock for the block.
- `reset_n` in 1: synchronous, active-low reset.
- `anode` in 8: active-low digit select. Bit i selects digit i.
- `cathodes` in 8: active-low segments. Bits [6:0] map to segments g,f,e,d,c,b,a. Bit [7] is dp.
- `disp_word` out 32: decoded digits. Digit i occupies bits [4i+3:4i].
- `dp_word` out 8: captured decimal point per digit, active-high.
- `digit_valid` out 8: digit i holds a legal decoded hex value.
- `frame_done` out 1: one-cycle pulse when all 8 digits have been captured since the last pulse or reset.
- `pattern_err` out 1: one-cycle pulse on a capture whose segment pattern is neither a hex glyph nor blank.
- `anode_err` out 1: one-cycle pulse on a capture with more than one anode low.

## Operation
- **Synchronizer.** Each input passes through a `SYNC_STAGES`-deep flop chain. On reset the chains load all ones (inactive).
- **Stability tracker.** The tracker is a 2-state FSM: WAIT and HOLD.
  - If the synced sample ≠ the previous synced sample, set `cnt` to 0 and go to WAIT.
  - In WAIT with an unchanged sample, increment `cnt`.
  - When `cnt` = `STABLE_CYCLES`-1 and the sample is unchanged, perform one capture and go to HOLD.
  - HOLD performs no further captures until the sample changes. Each stable interval therefore produces exactly one capture.
- **Capture, by anode count.**
  - Anode all ones (blanking interval): no action, no error.
  - More than one anode bit low: pulse `anode_err`. No digit state changes.
  - Exactly one anode bit i low: decode the cathode pattern, as below.
- **Decode.** Apply `s = ~cathodes[6:0]` (gfedcba, active-high). The legal glyphs are:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- **Result of a decode on digit i.**
  - Legal glyph: write the nibble to digit i, set `digit_valid[i]`, and set `dp_word[i] = ~cathodes[7]`.
  - `s` = 00 (blank): clear `digit_valid[i]`, write nibble 0, update `dp_word[i]`. No error.
  - Any other pattern: pulse `pattern_err`, clear `digit_valid[i]`, leave the nibble unchanged.
- **Frame tracking.**
  - An 8-bit `seen` mask sets bit i on every single-anode capture, whether legal, blank or error.
  - When the mask would become FF, pulse `frame_done` in the same cycle the final digit is written, and clear the mask to 00.
  - Recapturing a digit that is already seen does not pulse `frame_done`.
- **Counter.** `cnt` is ceil(log2(`STABLE_CYCLES`)) bits wide and saturates; it never wraps.

## Timing
- **Reset values.** All outputs are 0. State is WAIT, `cnt` and `seen` are 0, and the sync chains are all ones.
- **Reset priority.** `reset_n` low takes priority over everything. A reset mid-frame discards partial frame state; the first `frame_done` after reset requires 8 fresh captures.
- **Capture latency.** Suppose the pins settle before rising edge k and stay stable. The digit outputs, `digit_valid`, and the pulses then update on edge k+`SYNC_STAGES`+`STABLE_CYCLES`, and are visible for the cycle that follows.
- **Glitch rejection.** A pin pattern held fewer than `STABLE_CYCLES` cycles is never captured.
- **Pulse exclusivity.** `frame_done`, `pattern_err` and `anode_err` are single-cycle. `anode_err` and `pattern_err` are never asserted together.
- **Simultaneous error and frame completion.** `pattern_err` may coincide with `frame_done` when the completing digit is illegal.
- **Output stability.** `disp_word`, `dp_word` and `digit_valid` hold their values between captures.

## Test plan
1. **Reset.** Assert `reset_n`=0 for 3 cycles with random pins → all outputs 0. Release with the pins all ones for 100 cycles → no pulses.
2. **Single digit.** Hold `anode`=FE, `cathodes`=C0 for 30 cycles → on edge k+18, `disp_word[3:0]`=0, `digit_valid`=01, `dp_word`=00. No `frame_done`.
3. **Full frame.** Scan digits 0–7 showing 1,2,3,4,5,6,7,8, 20 cycles each, with 2-cycle all-ones blanking between digits → `disp_word`=87654321, `digit_valid`=FF. Exactly one `frame_done`, on the digit-7 capture.
4. **Glitch and recapture.** Apply `anode`=FB with a glyph held 10 cycles, then change the pattern → no capture. Hold one pattern for 200 cycles → exactly one capture.
5. **Errors.**
   - `anode`=FC held 20 cycles → one `anode_err` pulse, outputs unchanged.
   - `anode`=FE, `cathodes`=FE (segment a only) → one `pattern_err`, `digit_valid[0]`=0.
   - `cathodes`=7F (blank, dp on) → `digit_valid[0]`=0, `dp_word[0]`=1, no error.
6. **Mid-frame reset.** Capture digits 0–3, pulse `reset_n` low for 1 cycle, then scan all 8 → outputs 0 after the reset. `frame_done` is asserted only after the 8th post-reset capture.
